// File: rtl/hidden_mul.sv
// hidden_mul: LSTM hidden-state stage, h = og * tanh(c) in signed Q5.26.
// Rounds half up, saturates to the DW-bit range, reports each result as a
// one-cycle h_vld pulse and queues it in a show-ahead FIFO for the next
// timestep's MAC.
//
// Upstream handshake (en/comp): the tanh stage raises en with tanh/og stable
// and keeps en high until it sees comp. comp rises once the result has been
// written to the FIFO and stays high until en is sampled low. Each en
// assertion yields exactly one result. While the FIFO is full the request
// is simply not taken, so en stays high until space frees up.
//
// Read side: rd_data always shows the FIFO head. rd_pop is honoured only
// when the FIFO is not empty.
module hidden_mul #(
   parameter int DW    = 32,
   parameter int FRAC  = 26,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          locked,
   input  logic          en,
   input  logic [DW-1:0] tanh,
   input  logic [DW-1:0] og,
   output logic          comp,
   output logic [DW-1:0] h,
   output logic          h_vld,
   input  logic          rd_pop,
   output logic [DW-1:0] rd_data,
   output logic [AW:0]   count,
   output logic          empty,
   output logic          full,
   output logic [2:0]    o_dbg_state
);

   localparam int PW = 2 * DW;

   // Saturation limits and rounding constant, all in product width.
   localparam logic signed [PW-1:0] SAT_MAX  = (PW'(1) <<< (DW - 1)) - PW'(1);
   localparam logic signed [PW-1:0] SAT_MIN  = -(PW'(1) <<< (DW - 1));
   localparam logic signed [PW-1:0] RND_HALF = PW'(1) <<< (FRAC - 1);
   localparam logic [AW:0]          CNT_FULL = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MUL   = 3'd1,
      S_NORM  = 3'd2,
      S_WRITE = 3'd3,
      S_ACK   = 3'd4
   } state_t;

   // Datapath and control state.
   state_t                 r_state;
   logic signed [DW-1:0]   r_t;
   logic signed [DW-1:0]   r_o;
   logic signed [PW-1:0]   r_prod;
   logic [DW-1:0]          r_h;
   logic                   r_h_vld;
   logic                   r_comp;

   // FIFO storage and bookkeeping.
   logic [DW-1:0]          r_mem [DEPTH];
   logic [AW-1:0]          r_wr_ptr;
   logic [AW-1:0]          r_rd_ptr;
   logic [AW:0]            r_count;

   // Combinational helpers.
   logic signed [PW-1:0]   w_round;
   logic signed [PW-1:0]   w_shift;
   logic [DW-1:0]          w_sat;
   logic                   w_empty;
   logic                   w_full;
   logic                   w_write;
   logic                   w_pop;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_FULL);

   // A write happens on the edge that leaves WRITE. locked freezes the
   // whole block, so neither side of the FIFO moves while it is asserted.
   assign w_write = (r_state == S_WRITE) && !locked;
   assign w_pop   = rd_pop && !w_empty && !locked;

   // Round half up, arithmetic shift back to Q5.26, clamp to DW bits.
   always_comb begin
      w_round = r_prod + RND_HALF;
      w_shift = w_round >>> FRAC;
      w_sat   = w_shift[DW-1:0];
      if (w_shift > SAT_MAX) begin
         w_sat = SAT_MAX[DW-1:0];
      end else if (w_shift < SAT_MIN) begin
         w_sat = SAT_MIN[DW-1:0];
      end
   end

   // Handshake FSM with registered datapath and outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_t     <= '0;
         r_o     <= '0;
         r_prod  <= '0;
         r_h     <= '0;
         r_h_vld <= 1'b0;
         r_comp  <= 1'b0;
      end else if (locked) begin
         // Drop any in-flight result; captured operands are don't-care.
         r_state <= S_IDLE;
         r_h     <= '0;
         r_h_vld <= 1'b0;
         r_comp  <= 1'b0;
      end else begin
         r_h_vld <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_comp <= 1'b0;
               if (en && !w_full) begin
                  r_t     <= $signed(tanh);
                  r_o     <= $signed(og);
                  r_state <= S_MUL;
               end
            end
            S_MUL: begin
               r_prod  <= r_t * r_o;
               r_state <= S_NORM;
            end
            S_NORM: begin
               r_h     <= w_sat;
               r_h_vld <= 1'b1;
               r_state <= S_WRITE;
            end
            S_WRITE: begin
               r_comp  <= 1'b1;
               r_state <= S_ACK;
            end
            S_ACK: begin
               if (!en) begin
                  r_comp  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_comp  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves the
   // count unchanged while both pointers advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + (AW + 1)'(1);
            2'b01:   r_count <= r_count - (AW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents survive reset and locked.
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[r_wr_ptr] <= r_h;
      end
   end

   assign comp        = r_comp;
   assign h           = r_h;
   assign h_vld       = r_h_vld;
   assign rd_data     = r_mem[r_rd_ptr];
   assign count       = r_count;
   assign empty       = w_empty;
   assign full        = w_full;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hidden_mul.sv
// Testbench for hidden_mul: directed vectors with hand-computed results.
// Expected h values go into exp_q when a request is issued; a monitor
// compares them against h on every h_vld pulse. A second queue models the
// FIFO contents for rd_data checks.
module tb_hidden_mul;

   localparam int DW = 32;
   localparam int AW = 3;

   logic          clk;
   logic          rst;
   logic          locked;
   logic          en;
   logic [DW-1:0] tanh;
   logic [DW-1:0] og;
   logic          comp;
   logic [DW-1:0] h;
   logic          h_vld;
   logic          rd_pop;
   logic [DW-1:0] rd_data;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic [2:0]    dbg_state;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] fifo_q[$];

   int total = 0;
   int bad   = 0;

   hidden_mul #(.DW(32), .FRAC(26), .DEPTH(8), .AW(3)) dut (
      .clk(clk), .rst(rst), .locked(locked), .en(en), .tanh(tanh), .og(og),
      .comp(comp), .h(h), .h_vld(h_vld), .rd_pop(rd_pop), .rd_data(rd_data),
      .count(count), .empty(empty), .full(full), .o_dbg_state(dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every h_vld pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (h_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL h_unexpected: got 0x%08h expected no result", h);
         end else begin
            chk("h_value", h, exp_q.pop_front());
         end
      end
   end

   // Raise en with operands; the result is expected to land in h and the FIFO.
   task automatic issue(input logic [DW-1:0] t, input logic [DW-1:0] o, input logic [DW-1:0] e);
      exp_q.push_back(e);
      fifo_q.push_back(e);
      tanh = t;
      og   = o;
      en   = 1'b1;
   endtask

   // Count edges until comp rises (bounded); also note when h_vld was seen.
   task automatic wait_comp(output int n, output int hv_at);
      n = 0;
      hv_at = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (h_vld && hv_at == 0) hv_at = i;
         if (comp) begin
            n = i;
            break;
         end
      end
      if (n == 0) begin
         total++;
         bad++;
         $display("FAIL comp_timeout: got no comp expected comp within 20 cycles");
      end
   endtask

   // Drop en; the next edge must drop comp.
   task automatic release_en();
      en = 1'b0;
      @(posedge clk);
      #1;
      chk("comp_drop", 32'(comp), 32'd0);
   endtask

   // Full handshake with latency checks.
   task automatic hs(input logic [DW-1:0] t, input logic [DW-1:0] o, input logic [DW-1:0] e);
      int n;
      int hv;
      issue(t, o, e);
      wait_comp(n, hv);
      chk("comp_latency", 32'(n), 32'd4);
      chk("hvld_latency", 32'(hv), 32'd3);
      release_en();
   endtask

   // Pop one entry, checking the show-ahead head first.
   task automatic pop();
      if (fifo_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL pop_model: got pop expected model entry");
      end else begin
         chk("rd_data", rd_data, fifo_q.pop_front());
      end
      rd_pop = 1'b1;
      @(posedge clk);
      #1;
      rd_pop = 1'b0;
   endtask

   initial begin
      int n;
      int hv;
      rst    = 1'b0;
      locked = 1'b0;
      en     = 1'b0;
      tanh   = '0;
      og     = '0;
      rd_pop = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Reset state
      chk("rst_comp", 32'(comp), 32'd0);
      chk("rst_h", h, 32'h0);
      chk("rst_hvld", 32'(h_vld), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);

      // Basic products, rounding, saturation
      hs(32'h02000000, 32'h02000000, 32'h01000000);
      hs(32'hFE000000, 32'h04000000, 32'hFE000000);
      hs(32'h00000001, 32'h02000000, 32'h00000001);
      hs(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
      hs(32'h80000000, 32'h7FFFFFFF, 32'h80000000);
      chk("count5", 32'(count), 32'd5);
      repeat (5) pop();
      chk("drained_empty", 32'(empty), 32'd1);

      // Fill to DEPTH, then backpressure
      for (int i = 1; i <= 8; i++) begin
         hs(32'(i) << 24, 32'h04000000, 32'(i) << 24);
      end
      chk("full_flag", 32'(full), 32'd1);
      chk("full_count", 32'(count), 32'd8);
      issue(32'h09000000, 32'h04000000, 32'h09000000);
      repeat (6) @(posedge clk);
      #1;
      chk("bp_comp", 32'(comp), 32'd0);
      chk("bp_state", 32'(dbg_state), 32'd0);
      pop();
      wait_comp(n, hv);
      chk("bp_release_latency", 32'(n), 32'd4);
      release_en();
      chk("refill_count", 32'(count), 32'd8);
      repeat (8) pop();
      chk("drain_empty2", 32'(empty), 32'd1);

      // Pop coinciding with WRITE at count=3
      hs(32'h01000000, 32'h04000000, 32'h01000000);
      hs(32'h02000000, 32'h04000000, 32'h02000000);
      hs(32'h03000000, 32'h04000000, 32'h03000000);
      issue(32'h04000000, 32'h04000000, 32'h04000000);
      repeat (3) @(posedge clk);
      #1;
      chk("pre_write_state", 32'(dbg_state), 32'd3);
      pop();
      chk("simul_comp", 32'(comp), 32'd1);
      chk("simul_count", 32'(count), 32'd3);
      release_en();
      repeat (3) pop();
      chk("empty3", 32'(count), 32'd0);
      rd_pop = 1'b1;
      @(posedge clk);
      #1;
      rd_pop = 1'b0;
      chk("pop_empty_count", 32'(count), 32'd0);
      chk("pop_empty_flag", 32'(empty), 32'd1);

      // Reset during MUL
      hs(32'h02000000, 32'h04000000, 32'h02000000);
      tanh = 32'h01000000;
      og   = 32'h04000000;
      en   = 1'b1;
      @(posedge clk);
      #1;
      chk("in_mul", 32'(dbg_state), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_comp", 32'(comp), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_h", h, 32'h0);
      en = 1'b0;
      fifo_q.delete();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_state", 32'(dbg_state), 32'd0);

      // locked in ACK keeps FIFO data
      issue(32'h06000000, 32'h04000000, 32'h06000000);
      wait_comp(n, hv);
      chk("ack_state", 32'(dbg_state), 32'd4);
      locked = 1'b1;
      @(posedge clk);
      #1;
      locked = 1'b0;
      en     = 1'b0;
      chk("lock_comp", 32'(comp), 32'd0);
      chk("lock_state", 32'(dbg_state), 32'd0);
      chk("lock_h", h, 32'h0);
      chk("lock_count", 32'(count), 32'd1);
      pop();
      chk("final_empty", 32'(empty), 32'd1);

      repeat (3) @(posedge clk);
      #1;
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before limit");
      $fatal(1, "timeout");
   end

endmodule
